// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed, big-endian byte stream over valid/ready,
// writes whole words to consecutive IM addresses and releases the core only after a good checksum.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [16:0] MaxLen = 17'(MAX_WORDS);

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [7:0]            chk_q, chk_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           loaded_q, loaded_d;

  logic        accept;
  logic [15:0] len_rx;

  assign rx_ready     = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHK);
  assign busy         = rx_ready;
  assign accept       = rx_valid && rx_ready;
  assign len_rx       = {len_q[15:8], rx_data};
  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign words_loaded = loaded_q;

  always_comb begin
    // NOTE: every variable gets its hold/default value first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    loaded_d   = loaded_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          word_d     = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          chk_d      = '0;
          addr_d     = '0;
          loaded_d   = '0;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = len_rx;
          if (len_rx == 16'd0)              state_d = S_CHK;
          else if ({1'b0, len_rx} > MaxLen) state_d = S_ERR;
          else                              state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], rx_data};
          chk_d      = chk_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes a word: the write is issued from registers on the next cycle.
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            wdata_d    = {word_q[23:0], rx_data};
            loaded_d   = loaded_q + 16'd1;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == len_q - 16'd1) state_d = S_CHK;
          end
        end
      end

      S_CHK: begin
        if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      chk_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      loaded_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      loaded_q   <= loaded_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are streamed byte by byte and every IM write is
// captured and compared with hand-computed words.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [7:0]  frame[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  logic [15:0] wr_cnt[$];

  imem_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Capture every write pulse away from the rising edge.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(im_wdata);
      wr_cnt.push_back(words_loaded);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cnt.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'hxx;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame[i]) send_byte(frame[i], gaps);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] d0,
                              input logic [31:0] d1);
    check({tag, "_wr_count"}, wr_data.size(), n);
    for (int i = 0; i < n && i < wr_data.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), wr_addr[i], i);
      check($sformatf("%s_wr%0d_data", tag, i), wr_data[i], (i == 0) ? d0 : d1);
      check($sformatf("%s_wr%0d_cnt", tag, i), wr_cnt[i], i + 1);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                              input logic [15:0] exp_wl);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_words_loaded"}, words_loaded, exp_wl);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_im_we"}, im_we, 1'b0);
    check({tag, "_im_addr"}, im_addr, 8'h00);
    check({tag, "_im_wdata"}, im_wdata, 32'h0);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_words_loaded"}, words_loaded, 16'd0);
  endtask

  // Nominal two-word frame; checksum is the XOR of the eight data bytes (0x55).
  task automatic load_nominal(input logic [7:0] chk_byte);
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, chk_byte};
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Nominal load, one byte per cycle.
    clear_writes();
    do_start();
    check("start_busy", busy, 1'b1);
    check("start_hold", cpu_hold, 1'b1);
    load_nominal(8'h55);
    send_frame(1'b0);
    @(negedge clk);
    check_writes("nom", 2, 32'h20080005, 32'h01095020);
    check_status("nom", 1'b1, 1'b0, 16'd2);

    // Gaps between bytes, plus a start pulse mid-load that must be ignored.
    clear_writes();
    do_start();
    check("gap_done_cleared", done, 1'b0);
    check("gap_wl_cleared", words_loaded, 16'd0);
    for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b1);
    do_start();
    for (int i = 5; i < 11; i++) send_byte(frame[i], 1'b1);
    @(negedge clk);
    check_writes("gap", 2, 32'h20080005, 32'h01095020);
    check_status("gap", 1'b1, 1'b0, 16'd2);

    // Bad checksum: both words land, then ERR.
    clear_writes();
    do_start();
    load_nominal(8'h00);
    send_frame(1'b0);
    @(negedge clk);
    check_writes("badchk", 2, 32'h20080005, 32'h01095020);
    check_status("badchk", 1'b0, 1'b1, 16'd2);

    // Oversize length 257 aborts straight after LEN_LO.
    clear_writes();
    do_start();
    frame = '{8'h01, 8'h01};
    send_frame(1'b0);
    repeat (4) @(negedge clk);
    check_writes("over", 0, 32'h0, 32'h0);
    check_status("over", 1'b0, 1'b1, 16'd0);

    // Empty image: length 0 and checksum 0.
    clear_writes();
    do_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    @(negedge clk);
    check_writes("empty", 0, 32'h0, 32'h0);
    check_status("empty", 1'b1, 1'b0, 16'd0);

    // Reset after two bytes of the second word.
    clear_writes();
    do_start();
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09};
    send_frame(1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_writes("rstmid", 1, 32'h20080005, 32'h0);
    check_reset_vals("rstmid");
    reset = 1'b0;

    // Reset in the same cycle the fourth byte is accepted: the pending write is dropped.
    clear_writes();
    do_start();
    frame = '{8'h00, 8'h01, 8'h3C, 8'h01, 8'h10};
    send_frame(1'b0);
    @(negedge clk);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("rstpend", 0, 32'h0, 32'h0);
    check_reset_vals("rstpend");
    reset = 1'b0;

    // Fresh load after reset starts again from address 0.
    clear_writes();
    do_start();
    load_nominal(8'h55);
    send_frame(1'b0);
    @(negedge clk);
    check_writes("fresh", 2, 32'h20080005, 32'h01095020);
    check_status("fresh", 1'b1, 1'b0, 16'd2);

    // Reload from DONE with a one-word image.
    clear_writes();
    do_start();
    check("reload_done_drop", done, 1'b0);
    check("reload_hold", cpu_hold, 1'b1);
    check("reload_busy", busy, 1'b1);
    frame = '{8'h00, 8'h01, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h2C};
    send_frame(1'b0);
    @(negedge clk);
    check_writes("reload", 1, 32'h3C011001, 32'h0);
    check_status("reload", 1'b1, 1'b0, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
